// File: rtl/mdu.sv
// mdu -- multi-cycle multiply/divide unit sitting beside the ALU in EX.
//
// Runs mult/multu/div/divu over a fixed number of cycles into private HI/LO
// registers, and takes mthi/mtlo writes in a single cycle. HI/LO are plain
// register outputs feeding the EX result mux; busy feeds the hazard unit.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high; clears all state
//   Op1     in   32  rs operand (dividend / multiplicand / mthi-mtlo source)
//   Op2     in   32  rt operand (divisor / multiplier)
//   MDUOp   in   3   000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                    101 mthi, 110 mtlo, 111 none
//   en      in   instruction in EX is valid
//   start   out  combinational: en and a compute op (001..100) presented
//   busy    out  registered: compute op in progress
//   HI      out  32  HI register
//   LO      out  32  LO register
//   dz_err  out  registered one-cycle divide-by-zero pulse
//
// Optional feature macro: MDU_DIVZERO_FLAG_EN
//   defined   : dz_err pulses for one cycle after a div/divu with divisor 0
//               completes.
//   undefined : dz_err is tied to 0 and no flag logic exists.
//
// Parameters:
//   MULT_CYCLES  busy duration of mult/multu (>= 1)
//   DIV_CYCLES   busy duration of div/divu   (>= 1)
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | busy=0; accepts compute ops and mthi/mtlo when en=1
// RUN    | busy=1; counter counts N..1, result written at count 1

module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Op1,
  input  logic [31:0] Op2,
  input  logic [2:0]  MDUOp,
  input  logic        en,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        dz_err
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  // ---------------------------------------------------------------------
  // Datapath on the latched operands only
  // ---------------------------------------------------------------------
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] b_safe;
  logic [31:0] uq, ur;
  logic [31:0] a_mag, b_mag;
  logic [31:0] sq_mag, sr_mag;
  logic [31:0] sq, sr;
  logic        last_cycle;
  logic        div_by_zero;

  // Low 64 bits of a product of sign-extended operands equal the signed
  // 32x32 product, so one unsigned multiplier form covers both.
  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Divisor of zero never writes HI/LO; substituting 1 keeps the divider
  // free of X results without affecting any visible value.
  assign div_by_zero = (b_q == 32'd0);
  assign b_safe      = div_by_zero ? 32'd1 : b_q;

  assign uq = a_q / b_safe;
  assign ur = a_q % b_safe;

  // Signed divide through magnitudes: quotient truncates toward zero,
  // remainder follows the dividend sign. 0x80000000 / -1 falls out as
  // magnitude 0x80000000 with no negation, i.e. LO=0x80000000, HI=0.
  assign a_mag  = a_q[31]    ? (32'd0 - a_q)    : a_q;
  assign b_mag  = b_safe[31] ? (32'd0 - b_safe) : b_safe;
  assign sq_mag = a_mag / b_mag;
  assign sr_mag = a_mag % b_mag;
  assign sq     = (a_q[31] ^ b_safe[31]) ? (32'd0 - sq_mag) : sq_mag;
  assign sr     = a_q[31] ? (32'd0 - sr_mag) : sr_mag;

  assign last_cycle = (state_q == S_RUN) && (cnt_q == CNT_W'(1));

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          unique case (MDUOp)
            OP_MULT, OP_MULTU: begin
              op_d    = MDUOp;
              a_d     = Op1;
              b_d     = Op2;
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              op_d    = MDUOp;
              a_d     = Op1;
              b_d     = Op2;
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = S_RUN;
            end
            OP_MTHI: hi_d = Op1;
            OP_MTLO: lo_d = Op1;
            default: ;
          endcase
        end
      end

      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (last_cycle) begin
          state_d = S_IDLE;
          unique case (op_q)
            OP_MULT: begin
              hi_d = prod_s[63:32];
              lo_d = prod_s[31:0];
            end
            OP_MULTU: begin
              hi_d = prod_u[63:32];
              lo_d = prod_u[31:0];
            end
            OP_DIV: begin
              if (!div_by_zero) begin
                hi_d = sr;
                lo_d = sq;
              end
            end
            OP_DIVU: begin
              if (!div_by_zero) begin
                hi_d = ur;
                lo_d = uq;
              end
            end
            default: ;
          endcase
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 3'b000;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // ---------------------------------------------------------------------
  // Divide-by-zero flag
  // ---------------------------------------------------------------------
`ifdef MDU_DIVZERO_FLAG_EN
  logic dz_q;
  logic dz_d;

  assign dz_d = last_cycle && div_by_zero && ((op_q == OP_DIV) || (op_q == OP_DIVU));

  always_ff @(posedge clk) begin
    if (reset) begin
      dz_q <= 1'b0;
    end else begin
      dz_q <= dz_d;
    end
  end

  assign dz_err = dz_q;
`else
  assign dz_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign start = en && ((MDUOp == OP_MULT) || (MDUOp == OP_MULTU) ||
                        (MDUOp == OP_DIV)  || (MDUOp == OP_DIVU));
  assign busy  = (state_q == S_RUN);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the EX stage of the 5-stage pipeline, placed beside the ALU and fed from the same forwarded `Op1`/`Op2` operand buses. It runs `mult`, `multu`, `div` and `divu` over several cycles into private HI/LO registers. It also supports `mthi`/`mtlo` writes. HI/LO are driven combinationally to the EX-result mux for `mfhi`/`mflo`, and `busy` is driven to the hazard unit to stall MD-class instructions in ID.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of `mult`/`multu` (≥1)
- `DIV_CYCLES`, 10, busy duration of `div`/`divu` (≥1)

Ports (one clock `clk`; reset `reset` is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; clears all state
- `Op1`  in  32  rs operand, forwarded (dividend / multiplicand / mthi-mtlo source)
- `Op2`  in  32  rt operand, forwarded (divisor / multiplier)
- `MDUOp`  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none
- `en`  in  1  instruction in EX is valid; low for bubbles and flushed slots
- `start`  out  1  combinational: `en` and MDUOp ∈ {001..100}
- `busy`  out  1  registered; operation in progress
- `HI`  out  32  HI register
- `LO`  out  32  LO register
- `dz_err`  out  1  registered divide-by-zero pulse (see Configuration)

## Operation
- Reset values: `busy`=0, `HI`=0, `LO`=0, `dz_err`=0, counter=0, operand latches=0.
- Accept condition: `en && !busy`. When `busy`=1, every op is ignored. The hazard unit guarantees no MD instruction reaches EX while `busy || start`.
- Compute ops (001–100):
  - At the accepting edge, latch `Op1`, `Op2` and the op.
  - Set counter to `MULT_CYCLES` or `DIV_CYCLES` and set `busy`=1.
- While `busy`: each edge decrements the counter. At the edge where counter==1, write HI/LO and clear `busy`.
- States: IDLE (`busy`=0) → RUN (`busy`=1, counter N..1) → IDLE. No other states.
- `mthi`/`mtlo`: when accepted, `HI` or `LO` ← `Op1` at that edge. The other register is unchanged. `busy` stays 0.
- `mult`: signed 32×32→64; {HI,LO} = product. `multu`: unsigned likewise.
- `div`: signed. LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- `divu`: unsigned quotient to LO, remainder to HI.
- Divide by zero (`Op2`==0): runs the full `DIV_CYCLES`. HI and LO are left unchanged.
- Operand changes on `Op1`/`Op2` during RUN have no effect; only the latched operands are used.
- `MDUOp` 000/111, or `en`=0: no state change.

## Timing
- Start accepted at edge t: `busy`=1 from t+1 to t+N inclusive of cycles. Results visible and `busy`=0 after edge t+N.
- Back-to-back: a new start is accepted at edge t+N+1 at the earliest, i.e. on the first cycle `busy`=0.
- `HI`/`LO` outputs are register outputs with no bypass. `mfhi` issued while `busy` is stalled by the hazard unit, not by this block.
- `mthi` accepted at edge t: new HI visible in cycle t+1.
- Reset asserted mid-RUN: at that edge all state clears (`busy`=0, HI=LO=0). The aborted result is never written.
- Reset takes priority over accept when both are present at the same edge.

## Configuration
- Macro: `MDU_DIVZERO_FLAG_EN`.
- Defined: `dz_err` is 1 for exactly one cycle, the cycle after the completing edge, for a `div`/`divu` with latched divisor 0. Otherwise it is 0.
- Undefined: `dz_err` is constant 0 and no flag logic is synthesised. Divide-by-zero data behaviour (HI/LO unchanged) is identical in both builds.

## Test plan
- Reset, then `mult` Op1=0xFFFFFFFE (−2), Op2=3 → `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- `multu` Op1=0xFFFFFFFF, Op2=0xFFFFFFFF → after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- `div` Op1=0xFFFFFFF9 (−7), Op2=2 → `busy` 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then `divu` 7/0 → HI/LO unchanged after 10 cycles; `dz_err` pulses once only with `MDU_DIVZERO_FLAG_EN`.
- `mthi` 0x12345678 then `mtlo` 0x9ABCDEF0 on consecutive cycles → HI/LO update the next cycle each; `busy` stays 0. A `mthi` or `mult` presented while `busy`=1 → ignored.
- `en`=0 with MDUOp=001 → no `start`, `busy` stays 0, HI/LO unchanged.
- Start `div`, assert `reset` at RUN cycle 4 → next cycle `busy`=0, HI=LO=0. A new `mult` 6×7 then completes with LO=42 and HI=0.
